// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants, angle/gain tables and state type for the CORDIC engine
package cordic_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam longint PI_S32    = 64'sd13493037705;
    localparam longint K_INF_S32 = 64'sd2608131497;

    function automatic longint round_shift(input longint v, input int sh);
        if (sh > 0)
            return (v + (64'sd1 <<< (sh - 1))) >>> sh;
        else
            return v <<< (-sh);
    endfunction

    // atan(2^-i) with 24 fractional bits; rescaled below to the port's Q3 format
    function automatic longint atan_s24(input int i);
        longint v;
        case (i)
            0:       v = 64'sd13176795;
            1:       v = 64'sd7778716;
            2:       v = 64'sd4110060;
            3:       v = 64'sd2086331;
            4:       v = 64'sd1047214;
            5:       v = 64'sd524117;
            6:       v = 64'sd262123;
            7:       v = 64'sd131069;
            8:       v = 64'sd65536;
            9:       v = 64'sd32768;
            10:      v = 64'sd16384;
            11:      v = 64'sd8192;
            12:      v = 64'sd4096;
            13:      v = 64'sd2048;
            14:      v = 64'sd1024;
            15:      v = 64'sd512;
            16:      v = 64'sd256;
            17:      v = 64'sd128;
            18:      v = 64'sd64;
            19:      v = 64'sd32;
            20:      v = 64'sd16;
            21:      v = 64'sd8;
            22:      v = 64'sd4;
            23:      v = 64'sd2;
            default: v = 64'sd0;
        endcase
        return v;
    endfunction

    function automatic longint atan_q(input int i, input int frac);
        return round_shift(atan_s24(i), 24 - frac);
    endfunction

    function automatic longint pi_q(input int frac);
        return round_shift(PI_S32, 32 - frac);
    endfunction

    // Beyond six stages the gain is K_inf * (1 + (2/3) * 4^-n) to well below one LSB
    function automatic longint cordic_k(input int n, input int frac);
        longint k;
        case (n)
            1:       k = 64'sd3037000500;
            2:       k = 64'sd2716375821;
            3:       k = 64'sd2635271636;
            4:       k = 64'sd2614921742;
            5:       k = 64'sd2609829389;
            default: k = K_INF_S32 + (K_INF_S32 * 64'sd2) / (64'sd3 * (64'sd1 <<< (2 * n)));
        endcase
        return round_shift(k, 32 - frac);
    endfunction

endpackage

// File: rtl/cordic_engine_stage.sv
// rtl/cordic_engine_stage.sv - one combinational CORDIC micro-rotation
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int DW = 19
) (
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] y,
    input  logic signed [DW-1:0] z,
    input  logic [4:0]           shift,
    input  logic                 mode,
    input  logic signed [DW-1:0] atan,
    output logic signed [DW-1:0] x_next,
    output logic signed [DW-1:0] y_next,
    output logic signed [DW-1:0] z_next
);

    logic                 pos;
    logic signed [DW-1:0] xs;
    logic signed [DW-1:0] ys;

    // pos means d = +1: rotation follows sign(z), vectoring drives y toward zero
    assign pos = mode ? y[DW-1] : ~z[DW-1];
    assign xs  = x >>> shift;
    assign ys  = y >>> shift;

    always_comb begin
        x_next = x;
        y_next = y;
        z_next = z;
        if (pos) begin
            x_next = x - ys;
            y_next = y + xs;
            z_next = z - atan;
        end else begin
            x_next = x + ys;
            y_next = y - xs;
            z_next = z + atan;
        end
    end

endmodule

// File: rtl/cordic_engine.sv
// rtl/cordic_engine.sv - iterative rotation/vectoring CORDIC with start/done handshake
module cordic_engine
    import cordic_pkg::*;
#(
    parameter int W       = 18,
    parameter int ITER    = 16,
    parameter int PER_CYC = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic         start,
    input  logic         mode,
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic [W-1:0] theta_i,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] x_o,
    output logic [W-1:0] y_o,
    output logic [W-1:0] z_o
);

    localparam int DW    = W + 1;
    localparam int N_CYC = ITER / PER_CYC;

    localparam logic signed [DW-1:0] PI_Q   = DW'(pi_q(W - 3));
    localparam logic signed [DW-1:0] PI_2_Q = DW'(pi_q(W - 4));
    localparam logic signed [DW-1:0] K_Q    = DW'(cordic_k(ITER, W - 2));

    state_t state;
    state_t next_state;

    logic [4:0]           count;
    logic                 mode_r;
    logic                 neg;
    logic                 last;
    logic signed [DW-1:0] xr, yr, zr;
    logic signed [DW-1:0] xf, yf, zf;
    logic signed [DW-1:0] rx, ry;
    logic signed [DW-1:0] th, xi_s, yi_s;
    logic signed [DW-1:0] init_x, init_y, init_z;
    logic                 init_neg;

    function automatic logic [W-1:0] sat(input logic signed [DW-1:0] v);
        if (v[DW-1] != v[DW-2])
            return {v[DW-1], {(W-1){~v[DW-1]}}};
        else
            return v[W-1:0];
    endfunction

    assign busy = (state != S_IDLE);
    assign last = (count == 5'(N_CYC - 1));
    assign th   = DW'($signed(theta_i));
    assign xi_s = DW'($signed(x_i));
    assign yi_s = DW'($signed(y_i));

    always_comb begin
        init_x   = K_Q;
        init_y   = '0;
        init_z   = th;
        init_neg = 1'b0;
        if (!mode) begin
            // fold the angle into [-pi/2, pi/2] and flip the result sign instead
            if (th > PI_2_Q) begin
                init_z   = th - PI_Q;
                init_neg = 1'b1;
            end else if (th < -PI_2_Q) begin
                init_z   = th + PI_Q;
                init_neg = 1'b1;
            end
        end else if (xi_s < 0) begin
            init_x = -xi_s;
            init_y = -yi_s;
            init_z = (yi_s >= 0) ? PI_Q : -PI_Q;
        end else begin
            init_x = xi_s;
            init_y = yi_s;
            init_z = '0;
        end
    end

    genvar k;
    for (k = 0; k < PER_CYC; k++) begin : g_stage
        logic [4:0]           sh;
        logic signed [DW-1:0] at;
        logic signed [DW-1:0] xa, ya, za;
        logic signed [DW-1:0] xn, yn, zn;

        if (k == 0) begin : g_first
            assign xa = xr;
            assign ya = yr;
            assign za = zr;
        end else begin : g_next
            assign xa = g_stage[k-1].xn;
            assign ya = g_stage[k-1].yn;
            assign za = g_stage[k-1].zn;
        end

        assign sh = 5'(int'(count) * PER_CYC + k);
        assign at = DW'(atan_q(int'(sh), W - 3));

        cordic_stage #(.DW(DW)) u_stage (
            .x      (xa),
            .y      (ya),
            .z      (za),
            .shift  (sh),
            .mode   (mode_r),
            .atan   (at),
            .x_next (xn),
            .y_next (yn),
            .z_next (zn)
        );
    end

    assign xf = g_stage[PER_CYC-1].xn;
    assign yf = g_stage[PER_CYC-1].yn;
    assign zf = g_stage[PER_CYC-1].zn;
    assign rx = neg ? -xf : xf;
    assign ry = neg ? -yf : yf;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_BUSY;
            S_BUSY:  if (last)  next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else if (clk_en)
            state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done   <= 1'b0;
            count  <= '0;
            mode_r <= 1'b0;
            neg    <= 1'b0;
            xr     <= '0;
            yr     <= '0;
            zr     <= '0;
            x_o    <= '0;
            y_o    <= '0;
            z_o    <= '0;
        end else if (clk_en) begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_r <= mode;
                        neg    <= init_neg;
                        xr     <= init_x;
                        yr     <= init_y;
                        zr     <= init_z;
                        count  <= '0;
                    end
                end
                S_BUSY: begin
                    xr    <= xf;
                    yr    <= yf;
                    zr    <= zf;
                    count <= count + 5'd1;
                    if (last) begin
                        done <= 1'b1;
                        if (!mode_r) begin
                            x_o <= sat(rx);
                            y_o <= sat(ry);
                            z_o <= '0;
                        end else begin
                            x_o <= sat(xf);
                            y_o <= '0;
                            z_o <= sat(zf);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_engine.sv
// tb/tb_cordic_engine.sv - directed self-checking bench for cordic_engine
module tb_cordic_engine;

    localparam int TOL = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        start;
    logic        mode;
    logic [17:0] x_i;
    logic [17:0] y_i;
    logic [17:0] theta_i;
    logic        busy;
    logic        done;
    logic [17:0] x_o;
    logic [17:0] y_o;
    logic [17:0] z_o;

    int tests = 0;
    int fails = 0;

    cordic_engine #(.W(18), .ITER(16), .PER_CYC(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .start   (start),
        .mode    (mode),
        .x_i     (x_i),
        .y_i     (y_i),
        .theta_i (theta_i),
        .busy    (busy),
        .done    (done),
        .x_o     (x_o),
        .y_o     (y_o),
        .z_o     (z_o)
    );

    always #5 clk = ~clk;

    function automatic int sx(input logic [17:0] v);
        return int'($signed(v));
    endfunction

    // Operands are scrambled right after the start edge; the running operation must ignore them
    task automatic start_and_wait(output int lat);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        x_i     = 18'($urandom);
        y_i     = 18'($urandom);
        theta_i = 18'($urandom);
        mode    = ~mode;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_en = 1'b1; start = 1'b0; mode = 1'b0;
        x_i = '0; y_i = '0; theta_i = '0;
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        tests++; if (x_o !== 18'd0) begin fails++; $display("FAIL reset_x: got %h expected 0", x_o); end
        tests++; if (y_o !== 18'd0) begin fails++; $display("FAIL reset_y: got %h expected 0", y_o); end
        tests++; if (z_o !== 18'd0) begin fails++; $display("FAIL reset_z: got %h expected 0", z_o); end
        rst = 1'b0;
    endtask

    task automatic test_rotation();
        int lat, d;
        mode = 1'b0; theta_i = 18'h0860B;
        start_and_wait(lat);
        tests++; if (lat !== 8) begin fails++; $display("FAIL rot60_latency: got %0d expected 8", lat); end
        d = sx(x_o) - 32768;
        tests++; if (d > TOL || d < -TOL) begin fails++; $display("FAIL rot60_x: got %0d expected 32768+-16", sx(x_o)); end
        d = sx(y_o) - 56756;
        tests++; if (d > TOL || d < -TOL) begin fails++; $display("FAIL rot60_y: got %0d expected 56756+-16", sx(y_o)); end
        tests++; if (z_o !== 18'd0) begin fails++; $display("FAIL rot60_z: got %h expected 0", z_o); end
        @(negedge clk);
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL rot60_done_width: got %b expected 0", done); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rot60_idle: got busy %b expected 0", busy); end
    endtask

    task automatic test_range_reduction();
        int lat, d;
        mode = 1'b0; theta_i = 18'h19220;
        start_and_wait(lat);
        d = sx(x_o) + 65536;
        tests++; if (d > TOL || d < -TOL) begin fails++; $display("FAIL rot_pi_x: got %0d expected -65536+-16", sx(x_o)); end
        d = sx(y_o);
        tests++; if (d > TOL || d < -TOL) begin fails++; $display("FAIL rot_pi_y: got %0d expected 0+-16", sx(y_o)); end
        @(negedge clk);
        mode = 1'b0; theta_i = 18'(-77208);
        start_and_wait(lat);
        d = sx(x_o) + 46341;
        tests++; if (d > TOL || d < -TOL) begin fails++; $display("FAIL rot_m135_x: got %0d expected -46341+-16", sx(x_o)); end
        d = sx(y_o) + 46341;
        tests++; if (d > TOL || d < -TOL) begin fails++; $display("FAIL rot_m135_y: got %0d expected -46341+-16", sx(y_o)); end
        @(negedge clk);
    endtask

    task automatic test_vectoring();
        int lat, d;
        mode = 1'b1; x_i = 18'h08000; y_i = 18'h08000;
        start_and_wait(lat);
        tests++; if (lat !== 8) begin fails++; $display("FAIL vec45_latency: got %0d expected 8", lat); end
        d = sx(x_o) - 76311;
        tests++; if (d > TOL || d < -TOL) begin fails++; $display("FAIL vec45_mag: got %0d expected 76311+-16", sx(x_o)); end
        tests++; if (y_o !== 18'd0) begin fails++; $display("FAIL vec45_y: got %h expected 0", y_o); end
        d = sx(z_o) - 25736;
        tests++; if (d > TOL || d < -TOL) begin fails++; $display("FAIL vec45_angle: got %0d expected 25736+-16", sx(z_o)); end
        @(negedge clk);
        mode = 1'b1; x_i = 18'(-32768); y_i = 18'd0;
        start_and_wait(lat);
        d = sx(z_o) - 102944;
        tests++; if (d > TOL || d < -TOL) begin fails++; $display("FAIL vec180_angle: got %0d expected 102944+-16", sx(z_o)); end
        d = sx(x_o) - 53962;
        tests++; if (d > TOL || d < -TOL) begin fails++; $display("FAIL vec180_mag: got %0d expected 53962+-16", sx(x_o)); end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int n_done = 0;
        int first = -1;
        int second = -1;
        mode = 1'b0; theta_i = 18'h0860B;
        @(negedge clk);
        for (int e = 0; e <= 22; e++) begin
            start = (e == 0 || e == 3 || e == 9 || e == 10);
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (first < 0) first = e; else second = e;
            end
        end
        start = 1'b0;
        tests++; if (n_done !== 2) begin fails++; $display("FAIL busy_start_count: got %0d dones expected 2", n_done); end
        tests++; if (first !== 8) begin fails++; $display("FAIL busy_start_first: got edge %0d expected 8", first); end
        tests++; if (second !== 18) begin fails++; $display("FAIL busy_start_second: got edge %0d expected 18", second); end
    endtask

    task automatic test_clk_en();
        int en = 0;
        int d;
        bit seen = 0;
        mode = 1'b0; theta_i = 18'h0860B;
        @(negedge clk);
        clk_en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            clk_en = (c % 2 == 0);
            @(negedge clk);
            if (clk_en) en++;
            if (done === 1'b1) begin seen = 1; break; end
        end
        tests++; if (!seen || en !== 8) begin fails++; $display("FAIL clken_latency: got %0d enabled edges (seen %0d) expected 8", en, seen); end
        clk_en = 1'b0;
        @(negedge clk);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL clken_stretch: got done %b expected 1", done); end
        clk_en = 1'b1;
        @(negedge clk);
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL clken_release: got done %b expected 0", done); end
        d = sx(x_o) - 32768;
        tests++; if (d > TOL || d < -TOL) begin fails++; $display("FAIL clken_x: got %0d expected 32768+-16", sx(x_o)); end
        d = sx(y_o) - 56756;
        tests++; if (d > TOL || d < -TOL) begin fails++; $display("FAIL clken_y: got %0d expected 56756+-16", sx(y_o)); end
    endtask

    task automatic test_reset_mid_op();
        int n_done = 0;
        int lat, d;
        mode = 1'b0; theta_i = 18'h0860B;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        tests++; if ({x_o, y_o, z_o} !== 54'd0) begin fails++; $display("FAIL midrst_outputs: got %h %h %h expected 0 0 0", x_o, y_o, z_o); end
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        tests++; if (n_done !== 0) begin fails++; $display("FAIL midrst_no_done: got %0d dones expected 0", n_done); end
        mode = 1'b1; x_i = 18'h08000; y_i = 18'h08000;
        start_and_wait(lat);
        tests++; if (lat !== 8) begin fails++; $display("FAIL midrst_restart_latency: got %0d expected 8", lat); end
        d = sx(z_o) - 25736;
        tests++; if (d > TOL || d < -TOL) begin fails++; $display("FAIL midrst_restart_angle: got %0d expected 25736+-16", sx(z_o)); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_range_reduction();
        test_vectoring();
        test_start_while_busy();
        test_clk_en();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cordic_engine.md
# cordic_engine

Parametrised iterative CORDIC engine, successor to the single-mode sine/cosine unit. It supports both rotation mode (simultaneous cos and sin of an angle) and vectoring mode (magnitude and atan2 of an (x, y) pair). Data width, total iteration count and iterations per clock are set by parameters. It sits behind the peripheral register interface: it starts on a one-cycle `start` pulse, runs the iterations over several cycles, and reports completion with a one-cycle `done` pulse.

## Interface

Parameters:
- `W`, 18: width of all data and angle ports.
- `ITER`, 16: total micro-rotations. Must satisfy `ITER` ≤ `W`-2 and `ITER` ≤ 24.
- `PER_CYC`, 2: micro-rotations per enabled clock. Allowed values are 1, 2 or 4, and `PER_CYC` must divide `ITER`.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `clk_en`, in, 1: clock enable. When low, all state is frozen.
- `start`, in, 1: request a new operation. Sampled only in IDLE.
- `mode`, in, 1: 0 selects rotation, 1 selects vectoring. Latched at start.
- `x_i`, in, W: vectoring x input, signed Q2.(W-2).
- `y_i`, in, W: vectoring y input, signed Q2.(W-2).
- `theta_i`, in, W: rotation angle, signed Q3.(W-3) radians.
- `busy`, out, 1: high whenever state is not IDLE.
- `done`, out, 1: one-cycle completion pulse.
- `x_o`, out, W: rotation result cos θ, or vectoring result An·|v|. Q2.(W-2).
- `y_o`, out, W: rotation result sin θ. Driven to 0 in vectoring.
- `z_o`, out, W: vectoring result atan2(y, x), Q3.(W-3). Driven to 0 in rotation.

## Operation

- **States:** IDLE → BUSY → DONE → IDLE.
- **Operand latch (IDLE, `start`=1):** `mode` and the operands are latched, `count` is cleared and the state moves to BUSY.
- **Rotation, range reduction:** θ must lie in [-π, π].
  - If θ > π/2, use z = θ−π and set `neg`.
  - If θ < −π/2, use z = θ+π and set `neg`.
  - Otherwise use z = θ and clear `neg`.
  - Initial vector is x = K, y = 0, with K = ∏cos(atan 2^-i) for i = 0..`ITER`-1, rounded to Q2.
  - Direction per step: d = sign(z), with z ≥ 0 treated as +1.
- **Vectoring, pre-rotation:**
  - If x_i < 0: x = −x_i, y = −y_i, z = +π when y_i ≥ 0, else z = −π. Clear `neg`.
  - Otherwise: x = x_i, y = y_i, z = 0.
  - Direction per step: d = −sign(y), with y ≥ 0 treated as −1.
- **Micro-rotation i:**
  - x' = x − d·(y >>> i)
  - y' = y + d·(x >>> i)
  - z' = z − d·atan(2^-i)
  - Shifts are arithmetic. `PER_CYC` stages are chained combinationally, using indices `PER_CYC`·count … `PER_CYC`·count+`PER_CYC`-1.
- **Datapath width:** the internal x/y/z datapath is W+1 bits (one guard bit). Outputs saturate to the W-bit signed range.
- **Final BUSY cycle (count = `ITER`/`PER_CYC`−1):**
  - Rotation: x_o = ±x, y_o = ±y, negated when `neg` is set; z_o = 0.
  - Vectoring: x_o = x, y_o = 0, z_o = z.
  - State moves to DONE and `done` is set to 1.
- **DONE:** `done` returns to 0 and the state moves to IDLE. `start` is ignored in this state.
- **Output hold:** outputs hold their value until the next completion.
- **Vectoring gain:** the magnitude is not gain-compensated. An ≈ 1.6468 for `ITER` ≥ 10.
- **Out-of-contract inputs:** θ outside [-π, π], or |v|·An ≥ 2, gives undefined numeric output. The FSM still completes normally.

## Timing

- **Reset values:** state = IDLE, count = 0, `busy` = 0, `done` = 0, `x_o` = `y_o` = `z_o` = 0.
- **Latency:** `start` is sampled at edge 0. `done` goes high after enabled edge `ITER`/`PER_CYC` (8 with defaults) and stays high for exactly one enabled cycle.
- **Throughput:** back-to-back starts are accepted at most once every `ITER`/`PER_CYC`+2 enabled cycles (10 with defaults).
- **`start` while busy:** `start` in BUSY or DONE is ignored. It is not queued.
- **`clk_en` low:** all registers hold, including a held-high `done`, so the pulse stretches.
- **`rst` mid-operation:** returns to IDLE with all outputs zero on the next edge. No `done` is produced.
- **Operand changes after start:** changes to `x_i`, `y_i`, `theta_i` or `mode` after the start edge have no effect on the running operation.

## Structure

- **Package `cordic_pkg`:**
  - atan(2^-i) table for i = 0..23, as Q3 constants generated for the `W` in use, rounded to nearest.
  - `CORDIC_K` per `ITER`.
  - `PI` and `PI_2` in Q3 format.
  - State enum.
- **Sub-module `cordic_stage`:** one combinational micro-rotation. It takes x, y, z, shift index, direction select (mode) and atan value. The top module instantiates `PER_CYC` copies in series.

## Test plan

All scenarios use W=18, ITER=16, PER_CYC=2. Tolerance is ±16 LSB.

1. **Rotation, θ = π/3:** `mode`=0, `theta_i`=0x0860B → `done` after 8 cycles; `x_o` ≈ 0x08000 (0.5); `y_o` ≈ 0x0DDB4 (0.866).
2. **Rotation with range reduction, θ = 0x19220 (π):** → `x_o` ≈ −0x10000; `y_o` ≈ 0. Repeat with θ = −3π/4 → both outputs ≈ −0x0B505.
3. **Vectoring, x = y = 0x08000:** → `x_o` ≈ 0x12A17; `z_o` ≈ 0x06488 (π/4). Repeat with x = −0x08000, y = 0 → `z_o` ≈ 0x19220.
4. **`start` while busy:** pulse `start` at cycles 3 and 9 → only one `done`, at cycle 8. A second start at cycle 10 → `done` at cycle 18.
5. **`clk_en` toggling:** hold `clk_en` low on alternate cycles → `done` after 8 enabled edges, with results identical to scenario 1.
6. **Reset during BUSY:** assert `rst` at cycle 4 → next cycle `busy`=0 and all outputs 0; no `done`. A new start then succeeds.
